// File: rtl/imem_loadable_pkg.sv
// Shared types and constants for the loadable instruction memory.
// State encoding, the NOP fill word and the byte-to-word address shift.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } imem_state_t;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam int          IMEM_ADDR_LSB = 2;

endpackage

// File: rtl/imem_loadable_if.sv
// Loader and fetch port bundle for imem_loadable.
// The slave modport is the memory side; master is the loader/IF-stage side.
interface imem_loadable_if #(
    parameter int XLEN = 32,
    parameter int AW   = 6
);
    logic            load_start;
    logic            load_valid;
    logic            load_ready;
    logic [AW-1:0]   load_addr;
    logic [XLEN-1:0] load_data;
    logic            load_last;
    logic            fetch_req;
    logic [31:0]     fetch_addr;
    logic            fetch_ready;
    logic            fetch_hold;
    logic            fetch_valid;
    logic [XLEN-1:0] instruction;
    logic            fetch_err;
    logic            busy;

    modport slave (
        input  load_start, load_valid, load_addr, load_data, load_last,
        input  fetch_req, fetch_addr, fetch_hold,
        output load_ready, fetch_ready, fetch_valid, instruction, fetch_err, busy
    );

    modport master (
        output load_start, load_valid, load_addr, load_data, load_last,
        output fetch_req, fetch_addr, fetch_hold,
        input  load_ready, fetch_ready, fetch_valid, instruction, fetch_err, busy
    );
endinterface

// File: rtl/imem_loadable_ram.sv
// Single-write, single-registered-read RAM holding the program words.
// The read register only advances on i_re, so it doubles as the held response.
module imem_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr,
    output logic [XLEN-1:0] o_rdata
);
    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: self-clears to NOPs, takes a program, then serves fetches.
//   state    | meaning
//   ST_CLEAR | write NOP to every word, one per cycle, DEPTH cycles
//   ST_LOAD  | accept loader words until the one tagged load_last
//   ST_RUN   | serve fetches; load_start returns to ST_LOAD without clearing
module imem_loadable
    import imem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    imem_loadable_if.slave    bus
);
    imem_state_t     r_state;
    imem_state_t     w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt_nxt;

    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;
    logic            w_accept;
    logic            w_err;
    logic [AW-1:0]   w_idx;
    logic [XLEN-1:0] w_rdata;

    logic            r_fetch_valid;
    logic            r_fetch_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_we          = 1'b0;
        w_waddr       = '0;
        w_wdata       = '0;
        w_accept      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_we          = 1'b1;
                w_waddr       = r_clr_cnt;
                w_wdata       = XLEN'(NOP_WORD);
                w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.load_valid) begin
                    w_we    = 1'b1;
                    w_waddr = bus.load_addr;
                    w_wdata = bus.load_data;
                    if (bus.load_last) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_accept = bus.fetch_req && !bus.fetch_hold;
                if (bus.load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    assign w_idx = bus.fetch_addr[AW+IMEM_ADDR_LSB-1:IMEM_ADDR_LSB];
    assign w_err = (bus.fetch_addr[IMEM_ADDR_LSB-1:0] != '0)
                || (bus.fetch_addr[31:AW+IMEM_ADDR_LSB] != '0);

    imem_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_accept && !w_err),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    // Hold only freezes while in RUN; any other state drops the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else if (w_accept) begin
            r_fetch_valid <= 1'b1;
            r_fetch_err   <= w_err;
        end else if (!(r_state == ST_RUN && bus.fetch_hold)) begin
            r_fetch_valid <= 1'b0;
        end
    end

    assign bus.instruction = r_fetch_err ? '0 : w_rdata;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_err   = r_fetch_err;
    assign bus.load_ready  = (r_state == ST_LOAD);
    assign bus.fetch_ready = (r_state == ST_RUN) && !bus.fetch_hold;
    assign bus.busy        = (r_state != ST_RUN);
endmodule

// File: tb/tb_imem_loadable.sv
// Randomized self-checking bench for imem_loadable against an array model
// of program memory and the fetch response rules.
module tb_imem_loadable;
    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] mdl [DEPTH];
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_instr;

    imem_loadable_if #(.XLEN(XLEN), .AW(AW)) bus ();

    imem_loadable #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.fetch_hold = 1'b0;
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] expect_word(input logic [31:0] a);
        if (addr_err(a)) return 32'h0;
        return mdl[a / 4];
    endfunction

    // reset, then wait out CLEAR while hammering ignored inputs
    task automatic do_reset(input string tag);
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        chk({tag, "_rst_valid"}, 64'(bus.fetch_valid), 64'd0);
        chk({tag, "_rst_busy"},  64'(bus.busy), 64'd1);
        chk({tag, "_rst_lrdy"},  64'(bus.load_ready), 64'd0);
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_start = 1'b1;
        bus.fetch_req  = 1'b1;
        n = 0;
        while (!bus.load_ready && n < DEPTH + 8) begin
            bus.load_addr = AW'($urandom);
            bus.load_data = $urandom;
            step();
            n++;
            if (!bus.load_ready && bus.fetch_ready) begin
                chk({tag, "_clr_frdy"}, 64'(bus.fetch_ready), 64'd0);
            end
        end
        idle_inputs();
        chk({tag, "_clear_cycles"}, 64'(n), 64'(DEPTH));
        chk({tag, "_load_busy"}, 64'(bus.busy), 64'd1);
        chk({tag, "_load_fvalid"}, 64'(bus.fetch_valid), 64'd0);
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_addr  = a;
        bus.load_data  = d;
        bus.load_last  = last;
        step();
        mdl[a] = d;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    // single cycle fetch with request held high; leaves req asserted
    task automatic fetch(input string tag, input logic [31:0] a);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        step();
        e_valid = 1'b1;
        e_err   = addr_err(a);
        e_instr = expect_word(a);
        chk({tag, "_valid"}, 64'(bus.fetch_valid), 64'(e_valid));
        chk({tag, "_err"},   64'(bus.fetch_err),   64'(e_err));
        chk({tag, "_instr"}, 64'(bus.instruction), 64'(e_instr));
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom % 4)
            0, 1:    a = {24'h0, 6'($urandom), 2'b00};
            2:       a = {24'h0, 6'($urandom), 2'($urandom_range(1, 3))};
            default: a = $urandom | 32'h0000_0100;
        endcase
        return a;
    endfunction

    initial begin
        int          nw;
        logic [31:0] a;
        logic        req;
        logic        hold;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle_inputs();
        step();

        do_reset("r0");
        for (int i = 0; i < DEPTH + 2; i++) step();
        chk("idle_lrdy", 64'(bus.load_ready), 64'd1);
        load_word(6'd0, 32'h8C01_0001, 1'b1);
        chk("post_last_lrdy", 64'(bus.load_ready), 64'd0);
        chk("post_last_frdy", 64'(bus.fetch_ready), 64'd1);
        chk("post_last_busy", 64'(bus.busy), 64'd0);
        fetch("f0", 32'h0);
        fetch("f4", 32'h4);
        bus.fetch_req = 1'b0;
        step();
        chk("drop_valid", 64'(bus.fetch_valid), 64'd0);

        // reverse-order program, then back-to-back readback
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        chk("reload_lrdy", 64'(bus.load_ready), 64'd1);
        for (int i = 21; i >= 0; i--) load_word(AW'(i), $urandom, i == 0);
        for (int i = 0; i < 22; i++) fetch($sformatf("seq%0d", i), 32'(i * 4));
        fetch("mis2", 32'h2);
        fetch("oor100", 32'h100);

        // hold freezes the response and blocks acceptance
        fetch("hold_pre", 32'h0);
        bus.fetch_hold = 1'b1;
        bus.fetch_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_frdy", 64'(bus.fetch_ready), 64'd0);
            step();
            chk("hold_valid", 64'(bus.fetch_valid), 64'(e_valid));
            chk("hold_instr", 64'(bus.instruction), 64'(e_instr));
        end
        bus.fetch_hold = 1'b0;
        #1;
        chk("unhold_frdy", 64'(bus.fetch_ready), 64'd1);
        fetch("hold_post", 32'h8);

        // in-place reload of a single word
        bus.fetch_req  = 1'b0;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        step();
        chk("ld_fvalid", 64'(bus.fetch_valid), 64'd0);
        bus.fetch_req = 1'b1;
        step();
        chk("ld_ignore_fetch", 64'(bus.fetch_valid), 64'd0);
        bus.fetch_req = 1'b0;
        load_word(6'd3, 32'h0022_3820, 1'b1);
        for (int i = 0; i < 22; i++) fetch($sformatf("rl%0d", i), 32'(i * 4));

        // random program and random fetch/hold traffic
        bus.fetch_req  = 1'b0;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        nw = $urandom_range(4, 20);
        for (int i = 0; i < nw; i++) load_word(AW'($urandom), $urandom, i == nw - 1);
        fetch("rnd_pre", 32'h0);
        for (int i = 0; i < 200; i++) begin
            req  = ($urandom % 4) != 0;
            hold = ($urandom % 4) == 0;
            a    = rand_addr();
            bus.fetch_req  = req;
            bus.fetch_hold = hold;
            bus.fetch_addr = a;
            #1;
            chk("rnd_frdy", 64'(bus.fetch_ready), 64'(!hold));
            step();
            if (req && !hold) begin
                e_valid = 1'b1;
                e_err   = addr_err(a);
                e_instr = expect_word(a);
            end else if (!hold) begin
                e_valid = 1'b0;
            end
            chk("rnd_valid", 64'(bus.fetch_valid), 64'(e_valid));
            chk("rnd_err",   64'(bus.fetch_err),   64'(e_err));
            chk("rnd_instr", 64'(bus.instruction), 64'(e_instr));
        end
        idle_inputs();

        // reset in the middle of a load wipes everything
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 5; i++) load_word(AW'(i + 10), $urandom | 32'h1, 1'b0);
        do_reset("r1");
        load_word(AW'(40), 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < DEPTH; i++) fetch($sformatf("clr%0d", i), 32'(i * 4));
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory for the pipeline's IF stage. It replaces the fixed, reset-initialised program store with a RAM of configurable width and depth. After reset it clears itself to NOPs, then accepts a program over a valid/ready loader port, then serves fetches with a registered one-cycle read. It also flags misaligned and out-of-range fetch addresses, and supports in-place reload.

## Interface
Parameters:
- `XLEN`, default 32: instruction width in bits.
- `DEPTH`, default 64: number of words. Must be a power of 2 and at least 4.
- `AW`, default $clog2(DEPTH): word-index width.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load_start`  in  1: in RUN, requests a reload (go to LOAD).
- `load_valid`  in  1: loader word present.
- `load_ready`  out  1: high in LOAD only.
- `load_addr`  in  AW: word index to write.
- `load_data`  in  XLEN: instruction word.
- `load_last`  in  1: marks the final word of the program.
- `fetch_req`  in  1: fetch request.
- `fetch_addr`  in  32: byte address.
- `fetch_ready`  out  1: equals state==RUN && !fetch_hold.
- `fetch_hold`  in  1: pipeline stall. The response registers freeze.
- `fetch_valid`  out  1: response valid.
- `instruction`  out  XLEN: fetched word.
- `fetch_err`  out  1: the response came from a misaligned or out-of-range address.
- `busy`  out  1: high in CLEAR or LOAD.

## Operation
- States: CLEAR, LOAD, RUN.
- Reset:
  - state=CLEAR, clear counter=0.
  - `fetch_valid`=0, `instruction`=0, `fetch_err`=0, `busy`=1, `load_ready`=0.
- CLEAR:
  - Writes NOP (all zeros) to word[cnt] each cycle and increments cnt.
  - After the write of DEPTH-1, goes to LOAD. Takes exactly DEPTH cycles.
  - Loader and fetch inputs are ignored.
- LOAD:
  - On `load_valid && load_ready`, writes `load_data` to word[`load_addr`].
  - If `load_last` accompanies the write, goes to RUN on the next cycle.
  - Unwritten words remain NOP.
  - Words may be written in any order. A repeated address overwrites.
- RUN, fetch accepted on `fetch_req && fetch_ready`:
  - idx = `fetch_addr[AW+1:2]`.
  - err = (`fetch_addr[1:0]` != 0) || (`fetch_addr[31:AW+2]` != 0).
  - If err: `instruction` <= 0, `fetch_err` <= 1.
  - Otherwise: `instruction` <= word[idx], `fetch_err` <= 0.
  - `fetch_valid` <= 1.
- RUN, no accepted fetch: `fetch_valid` <= 0, unless `fetch_hold`=1, in which case all three response registers hold.
- `load_start` in RUN:
  - Goes to LOAD next cycle. The memory contents are kept and are not cleared.
  - A fetch accepted in the same cycle still completes.
- Leaving RUN: `fetch_valid` is forced to 0 on the first cycle in LOAD.

## Timing
- Fetch latency is 1 cycle: a request accepted at edge N has its response valid after edge N+1. Sustained throughput is one fetch per cycle.
- A read of a word written in the same cycle is impossible, because writes and fetches are never in the same state.
- Load handshake:
  - One word per cycle while `load_ready` is high.
  - `load_ready` drops the cycle after the `load_last` write.
  - Sequence with `load_last` on the write at edge K: RUN from edge K+1, first fetch accepted at K+1, response valid after K+2.
- Reset mid-operation (any state) restarts CLEAR next cycle.
  - Stored contents are zeroed over DEPTH cycles.
  - A partial load or in-flight fetch is discarded: `fetch_valid`=0 immediately after the reset edge.
- `load_start` asserted outside RUN is ignored. `load_valid` outside LOAD is ignored and produces no write.
- `fetch_hold`=1 together with `fetch_req`: the request is not accepted (`fetch_ready`=0). The requester must hold it.

## Structure
- Shared package `imem_pkg` holds:
  - `imem_state_t` (CLEAR/LOAD/RUN).
  - `NOP_WORD` (32'h0000_0000, i.e. sll $0,$0,0).
  - `IMEM_ADDR_LSB`=2.
- Sub-module `imem_ram`:
  - Synchronous single-write, single-registered-read RAM, XLEN x DEPTH.
  - The write port is muxed between the clear counter and the loader.
- The FSM, error detection, and hold logic live in the top module.

## Test plan
- Reset, then idle DEPTH+2 cycles, then one load with `load_last` at addr 0 of 32'h8C01_0001, then fetch 0x0 and 0x4 -> `busy` high for exactly DEPTH cycles after the reset edge, then stays high in LOAD until the `load_last` write. Fetch 0x0 returns 32'h8C01_0001. Fetch 0x4 returns 0 with `fetch_err`=0.
- Load words 0..21 in reverse order, last on idx 0, then fetch 0x00..0x54 back-to-back -> each response is valid one cycle after its request, with the data matching the loaded words in idx order.
- Fetch 0x2 and 0x100 (DEPTH=64) -> `instruction`=0, `fetch_err`=1, `fetch_valid`=1.
- Fetch 0x0, then assert `fetch_hold` for 3 cycles with `fetch_req` high -> the response is frozen, `fetch_ready`=0, and the next fetch is accepted on the first cycle after hold drops.
- In RUN, assert `load_start`, overwrite idx 3 with 32'h0022_3820 plus `load_last` -> fetch 0xC returns the new word, and other words are unchanged.
- Assert `rst` mid-LOAD after 5 writes -> `fetch_valid`=0, CLEAR runs DEPTH cycles, and all words read 0 after the reload.
